// File: rtl/intan_pkg.sv
// Shared constants and state encodings for the Intan frame packer.
// The frame is 2 sync bytes, a frame counter, N_CH big-endian samples, then an XOR checksum.
package intan_pkg;

  localparam int N_CH        = 16;
  localparam int CH_W        = $clog2(N_CH);
  localparam int FRAME_BYTES = 3 + 2 * N_CH + 1;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_HDR0,
    TX_HDR1,
    TX_FCNT,
    TX_S_HI,
    TX_S_LO,
    TX_CSUM
  } tx_state_t;

  typedef enum logic {
    CAP_WAIT0,
    CAP_FILL
  } cap_state_t;

endpackage

// File: rtl/intan_frame_packer_if.sv
// Sample input bus, byte stream and status flags of the frame packer.
// The sequencer/host side uses master; the packer itself uses slave.
interface intan_frame_packer_if;

  logic        DATA_VALID;
  logic [15:0] RESULT;
  logic [7:0]  ELECTRODE;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        FRAME_DROP;
  logic        SEQ_ERR;

  modport master (
    output DATA_VALID, RESULT, ELECTRODE, OUT_READY,
    input  OUT_DATA, OUT_VALID, FRAME_DROP, SEQ_ERR
  );

  modport slave (
    input  DATA_VALID, RESULT, ELECTRODE, OUT_READY,
    output OUT_DATA, OUT_VALID, FRAME_DROP, SEQ_ERR
  );

endinterface

// File: rtl/intan_frame_buf.sv
// Two-bank sample store (2 x N_CH x 16 bit) with one write port and a registered read port.
// No reset: bank occupancy is tracked by the packer, so stale contents are never read.
module intan_frame_buf
  import intan_pkg::*;
(
  input  logic            clk,
  input  logic            wr_en,
  input  logic            wr_bank,
  input  logic [CH_W-1:0] wr_idx,
  input  logic [15:0]     wr_data,
  input  logic            rd_bank,
  input  logic [CH_W-1:0] rd_idx,
  output logic [15:0]     rd_data
);

  logic [15:0] mem [2*N_CH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_idx}] <= wr_data;
    end
    rd_data <= mem[{rd_bank, rd_idx}];
  end

endmodule

// File: rtl/intan_frame_packer.sv
// Groups one ELECTRODE 0..N_CH-1 scan into a ping-pong banked frame and streams it as
// A5 5A fcnt {hi,lo}*N_CH csum over a valid/ready byte handshake.
module intan_frame_packer
  import intan_pkg::*;
(
  input  logic                 FPGA_CLK,
  input  logic                 RESET,
  intan_frame_packer_if.slave  bus
);

  // Sample edge detect
  logic dv_prev_reg;
  logic sample_ev;
  logic elec_is_zero;
  logic elec_is_exp;

  // Capture side
  cap_state_t      cap_state_reg, cap_state_next;
  logic [CH_W-1:0] exp_idx_reg, exp_idx_next;
  logic            wbank_reg, wbank_next;
  logic            frame_ok_reg, frame_ok_next;
  logic            seq_err_reg, seq_err_next;
  logic            drop_reg, drop_next;
  logic [1:0]      full_reg, full_next;
  logic            wbank_busy;
  logic            wr_en;
  logic [CH_W-1:0] wr_idx;

  // Transmit side
  tx_state_t       tx_state_reg, tx_state_next;
  logic [CH_W-1:0] ch_idx_reg, ch_idx_next;
  logic            rbank_reg, rbank_next;
  logic [7:0]      fcnt_reg, fcnt_next;
  logic [7:0]      csum_reg, csum_next;
  logic [CH_W-1:0] rd_idx;
  logic [15:0]     rd_data;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            hs;
  logic            tx_free;

  assign sample_ev    = bus.DATA_VALID && !dv_prev_reg;
  assign elec_is_zero = (bus.ELECTRODE == 8'd0);
  assign elec_is_exp  = (bus.ELECTRODE == {{(8-CH_W){1'b0}}, exp_idx_reg});

  assign out_valid = (tx_state_reg != TX_IDLE);
  assign hs        = out_valid && bus.OUT_READY;
  assign tx_free   = (tx_state_reg == TX_CSUM) && hs;

  // A bank whose last byte is handshaking this cycle already counts as free.
  assign wbank_busy = full_reg[wbank_reg] && !(tx_free && (rbank_reg == wbank_reg));

  intan_frame_buf u_buf (
    .clk     (FPGA_CLK),
    .wr_en   (wr_en),
    .wr_bank (wbank_reg),
    .wr_idx  (wr_idx),
    .wr_data (bus.RESULT),
    .rd_bank (rbank_reg),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge FPGA_CLK) begin
    if (RESET) begin
      dv_prev_reg   <= 1'b1;
      cap_state_reg <= CAP_WAIT0;
      exp_idx_reg   <= '0;
      wbank_reg     <= 1'b0;
      frame_ok_reg  <= 1'b0;
      seq_err_reg   <= 1'b0;
      drop_reg      <= 1'b0;
      full_reg      <= 2'b00;
      tx_state_reg  <= TX_IDLE;
      ch_idx_reg    <= '0;
      rbank_reg     <= 1'b0;
      fcnt_reg      <= 8'd0;
      csum_reg      <= 8'd0;
    end else begin
      dv_prev_reg   <= bus.DATA_VALID;
      cap_state_reg <= cap_state_next;
      exp_idx_reg   <= exp_idx_next;
      wbank_reg     <= wbank_next;
      frame_ok_reg  <= frame_ok_next;
      seq_err_reg   <= seq_err_next;
      drop_reg      <= drop_next;
      full_reg      <= full_next;
      tx_state_reg  <= tx_state_next;
      ch_idx_reg    <= ch_idx_next;
      rbank_reg     <= rbank_next;
      fcnt_reg      <= fcnt_next;
      csum_reg      <= csum_next;
    end
  end

  // Capture FSM. Whether a frame can be kept is decided when it starts: if the write bank
  // is still queued for transmit, the samples are not written and the frame is dropped
  // on completion, so a pending bank is never overwritten.
  always_comb begin
    cap_state_next = cap_state_reg;
    exp_idx_next   = exp_idx_reg;
    wbank_next     = wbank_reg;
    frame_ok_next  = frame_ok_reg;
    seq_err_next   = seq_err_reg;
    drop_next      = drop_reg;
    full_next      = full_reg;
    wr_en          = 1'b0;
    wr_idx         = exp_idx_reg;

    if (tx_free) begin
      full_next[rbank_reg] = 1'b0;
    end

    if (sample_ev) begin
      unique case (cap_state_reg)
        CAP_WAIT0: begin
          if (elec_is_zero) begin
            cap_state_next = CAP_FILL;
            exp_idx_next   = CH_W'(1);
            frame_ok_next  = !wbank_busy;
            wr_en          = !wbank_busy;
            wr_idx         = '0;
          end
        end
        CAP_FILL: begin
          if (elec_is_exp) begin
            wr_en = frame_ok_reg;
            if (exp_idx_reg == CH_W'(N_CH - 1)) begin
              cap_state_next = CAP_WAIT0;
              exp_idx_next   = '0;
              if (frame_ok_reg) begin
                full_next[wbank_reg] = 1'b1;
                wbank_next           = ~wbank_reg;
              end else begin
                drop_next = 1'b1;
              end
            end else begin
              exp_idx_next = exp_idx_reg + CH_W'(1);
            end
          end else begin
            seq_err_next = 1'b1;
            if (elec_is_zero) begin
              exp_idx_next  = CH_W'(1);
              frame_ok_next = !wbank_busy;
              wr_en         = !wbank_busy;
              wr_idx        = '0;
            end else begin
              cap_state_next = CAP_WAIT0;
              exp_idx_next   = '0;
            end
          end
        end
        default: begin
          cap_state_next = CAP_WAIT0;
        end
      endcase
    end
  end

  // TX FSM. The RAM read address runs one state ahead of S_HI, and is only advanced on a
  // handshake, so a stalled byte keeps re-reading the same word and stays constant.
  always_comb begin
    tx_state_next = tx_state_reg;
    ch_idx_next   = ch_idx_reg;
    rbank_next    = rbank_reg;
    fcnt_next     = fcnt_reg;
    csum_next     = csum_reg;
    rd_idx        = ch_idx_reg;
    out_data      = 8'd0;

    unique case (tx_state_reg)
      TX_IDLE: begin
        ch_idx_next = '0;
        if (full_reg[rbank_reg]) begin
          tx_state_next = TX_HDR0;
        end
      end
      TX_HDR0: begin
        out_data = SYNC0;
        if (hs) tx_state_next = TX_HDR1;
      end
      TX_HDR1: begin
        out_data = SYNC1;
        if (hs) tx_state_next = TX_FCNT;
      end
      TX_FCNT: begin
        out_data = fcnt_reg;
        if (hs) begin
          csum_next     = fcnt_reg;
          tx_state_next = TX_S_HI;
        end
      end
      TX_S_HI: begin
        out_data = rd_data[15:8];
        if (hs) begin
          csum_next     = csum_reg ^ rd_data[15:8];
          tx_state_next = TX_S_LO;
        end
      end
      TX_S_LO: begin
        out_data = rd_data[7:0];
        if (hs) begin
          csum_next = csum_reg ^ rd_data[7:0];
          if (ch_idx_reg == CH_W'(N_CH - 1)) begin
            ch_idx_next   = '0;
            tx_state_next = TX_CSUM;
          end else begin
            ch_idx_next   = ch_idx_reg + CH_W'(1);
            rd_idx        = ch_idx_reg + CH_W'(1);
            tx_state_next = TX_S_HI;
          end
        end
      end
      TX_CSUM: begin
        out_data = csum_reg;
        if (hs) begin
          fcnt_next  = fcnt_reg + 8'd1;
          rbank_next = ~rbank_reg;
          ch_idx_next = '0;
          tx_state_next = full_reg[~rbank_reg] ? TX_HDR0 : TX_IDLE;
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
      end
    endcase
  end

  assign bus.OUT_DATA   = out_data;
  assign bus.OUT_VALID  = out_valid;
  assign bus.FRAME_DROP = drop_reg;
  assign bus.SEQ_ERR    = seq_err_reg;

endmodule

// File: tb/tb_intan_frame_packer.sv
// Directed bench for intan_frame_packer: scans are driven as sample strobes and every
// accepted byte is collected and checked against frames built from the sample values.
module tb_intan_frame_packer;
  import intan_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intan_frame_packer_if bus();

  intan_frame_packer dut (
    .FPGA_CLK (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  logic [7:0] rx_q[$];
  int         stamp_q[$];
  logic [7:0] gapless_q[$];
  logic [7:0] exp_f [2*FRAME_BYTES];

  always @(posedge clk) cycle <= cycle + 1;

  // Bytes are taken on the negedge before the posedge that consumes them.
  always @(negedge clk) begin
    if (!rst && bus.OUT_VALID && bus.OUT_READY) begin
      rx_q.push_back(bus.OUT_DATA);
      stamp_q.push_back(cycle);
    end
  end

  function automatic logic [15:0] sval(input logic [15:0] base, input logic [15:0] step, input int ch);
    return 16'(base + step * 16'(ch));
  endfunction

  // Reference frame: A5 5A fcnt, samples hi/lo, XOR of fcnt and sample bytes.
  task automatic build_frame(input int slot, input logic [7:0] fc, input logic [15:0] base,
                             input logic [15:0] step);
    logic [7:0]  cs;
    logic [15:0] w;
    int          o;
    o = slot * FRAME_BYTES;
    exp_f[o]   = 8'hA5;
    exp_f[o+1] = 8'h5A;
    exp_f[o+2] = fc;
    cs = fc;
    for (int ch = 0; ch < N_CH; ch++) begin
      w = sval(base, step, ch);
      exp_f[o+3+2*ch] = w[15:8];
      exp_f[o+4+2*ch] = w[7:0];
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    exp_f[o+FRAME_BYTES-1] = cs;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.DATA_VALID = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rx_q.delete();
    stamp_q.delete();
  endtask

  task automatic send_sample(input logic [7:0] elec, input logic [15:0] val);
    @(posedge clk); #1;
    bus.ELECTRODE  = elec;
    bus.RESULT     = val;
    bus.DATA_VALID = 1'b1;
    @(posedge clk); #1;
    bus.DATA_VALID = 1'b0;
  endtask

  task automatic send_scan(input logic [15:0] base, input logic [15:0] step);
    for (int ch = 0; ch < N_CH; ch++) send_sample(8'(ch), sval(base, step, ch));
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (bus.OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.OUT_VALID); end
    tests_run++; if (bus.OUT_DATA !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", bus.OUT_DATA); end
    tests_run++; if (bus.FRAME_DROP !== 1'b0) begin tests_failed++; $display("FAIL reset_drop: got %b expected 0", bus.FRAME_DROP); end
    tests_run++; if (bus.SEQ_ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_seq: got %b expected 0", bus.SEQ_ERR); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_gapless();
    int gaps;
    logic [7:0] got;
    do_reset();
    bus.OUT_READY = 1'b1;
    send_scan(16'h1000, 16'h0001);
    send_scan(16'h1000, 16'h0001);
    drain(120);
    tests_run++; if (rx_q.size() != 2*FRAME_BYTES) begin tests_failed++; $display("FAIL gapless_len: got %0d expected %0d", rx_q.size(), 2*FRAME_BYTES); end
    build_frame(0, 8'h00, 16'h1000, 16'h0001);
    build_frame(1, 8'h01, 16'h1000, 16'h0001);
    for (int i = 0; i < 2*FRAME_BYTES; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== exp_f[i]) begin tests_failed++; $display("FAIL gapless_byte%0d: got %h expected %h", i, got, exp_f[i]); end
    end
    if (rx_q.size() == 2*FRAME_BYTES) begin
      tests_run++; if (rx_q[3] !== 8'h10 || rx_q[4] !== 8'h00 || rx_q[34] !== 8'h0F) begin tests_failed++; $display("FAIL gapless_ch: got %h %h %h expected 10 00 0F", rx_q[3], rx_q[4], rx_q[34]); end
      tests_run++; if (rx_q[35] !== 8'h00) begin tests_failed++; $display("FAIL gapless_csum0: got %h expected 00", rx_q[35]); end
      tests_run++; if (rx_q[38] !== 8'h01 || rx_q[71] !== 8'h01) begin tests_failed++; $display("FAIL gapless_frame1: got fcnt %h csum %h expected 01 01", rx_q[38], rx_q[71]); end
      gaps = 0;
      for (int i = 1; i < 2*FRAME_BYTES; i++) if (stamp_q[i] != stamp_q[i-1] + 1) gaps++;
      tests_run++; if (gaps != 0) begin tests_failed++; $display("FAIL gapless_rate: got %0d gaps expected 0", gaps); end
    end
    gapless_q = rx_q;
    $display("[TB] test_gapless: %0d bytes received", rx_q.size());
  endtask

  task automatic test_misaligned();
    logic [7:0] got;
    do_reset();
    bus.OUT_READY = 1'b1;
    send_sample(8'd14, 16'hEEEE);
    send_sample(8'd15, 16'hFFFF);
    send_scan(16'h2000, 16'h0101);
    drain(80);
    tests_run++; if (rx_q.size() != FRAME_BYTES) begin tests_failed++; $display("FAIL misaligned_len: got %0d expected %0d", rx_q.size(), FRAME_BYTES); end
    build_frame(0, 8'h00, 16'h2000, 16'h0101);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== exp_f[i]) begin tests_failed++; $display("FAIL misaligned_byte%0d: got %h expected %h", i, got, exp_f[i]); end
    end
    tests_run++; if (bus.SEQ_ERR !== 1'b0) begin tests_failed++; $display("FAIL misaligned_seq: got %b expected 0", bus.SEQ_ERR); end
    $display("[TB] test_misaligned: %0d bytes received", rx_q.size());
  endtask

  task automatic test_seq_err();
    logic [7:0] got;
    do_reset();
    bus.OUT_READY = 1'b1;
    for (int ch = 0; ch < 8; ch++) send_sample(8'(ch), 16'(16'h3000 + ch));
    send_sample(8'd9, 16'h3009);
    @(negedge clk);
    tests_run++; if (bus.SEQ_ERR !== 1'b1) begin tests_failed++; $display("FAIL seq_err_flag: got %b expected 1", bus.SEQ_ERR); end
    drain(60);
    tests_run++; if (rx_q.size() != 0) begin tests_failed++; $display("FAIL seq_err_nofr: got %0d bytes expected 0", rx_q.size()); end
    send_scan(16'h3100, 16'h0203);
    drain(80);
    tests_run++; if (rx_q.size() != FRAME_BYTES) begin tests_failed++; $display("FAIL seq_err_len: got %0d expected %0d", rx_q.size(), FRAME_BYTES); end
    build_frame(0, 8'h00, 16'h3100, 16'h0203);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== exp_f[i]) begin tests_failed++; $display("FAIL seq_err_byte%0d: got %h expected %h", i, got, exp_f[i]); end
    end
    $display("[TB] test_seq_err: %0d bytes received", rx_q.size());
  endtask

  task automatic test_backpressure();
    logic [7:0] got;
    do_reset();
    bus.OUT_READY = 1'b0;
    send_scan(16'h4000, 16'h0011);
    send_scan(16'h4800, 16'h0013);
    @(negedge clk);
    tests_run++; if (bus.FRAME_DROP !== 1'b0) begin tests_failed++; $display("FAIL bp_nodrop: got %b expected 0", bus.FRAME_DROP); end
    send_scan(16'h4F00, 16'h0017);
    @(negedge clk);
    tests_run++; if (bus.FRAME_DROP !== 1'b1) begin tests_failed++; $display("FAIL bp_drop: got %b expected 1", bus.FRAME_DROP); end
    tests_run++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 8'hA5) begin tests_failed++; $display("FAIL bp_hold: got valid %b data %h expected 1 a5", bus.OUT_VALID, bus.OUT_DATA); end
    tests_run++; if (rx_q.size() != 0) begin tests_failed++; $display("FAIL bp_stalled: got %0d bytes expected 0", rx_q.size()); end
    @(posedge clk); #1 bus.OUT_READY = 1'b1;
    drain(120);
    tests_run++; if (rx_q.size() != 2*FRAME_BYTES) begin tests_failed++; $display("FAIL bp_len: got %0d expected %0d", rx_q.size(), 2*FRAME_BYTES); end
    build_frame(0, 8'h00, 16'h4000, 16'h0011);
    build_frame(1, 8'h01, 16'h4800, 16'h0013);
    for (int i = 0; i < 2*FRAME_BYTES; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== exp_f[i]) begin tests_failed++; $display("FAIL bp_byte%0d: got %h expected %h", i, got, exp_f[i]); end
    end
    tests_run++; if (bus.FRAME_DROP !== 1'b1) begin tests_failed++; $display("FAIL bp_sticky: got %b expected 1", bus.FRAME_DROP); end
    $display("[TB] test_backpressure: %0d bytes received", rx_q.size());
  endtask

  task automatic test_random_ready();
    logic [7:0] got;
    logic [7:0] data_prev;
    logic       stall_prev;
    int         stalls;
    do_reset();
    bus.OUT_READY = 1'b0;
    stall_prev = 1'b0;
    data_prev  = 8'h00;
    stalls     = 0;
    fork
      begin
        send_scan(16'h1000, 16'h0001);
        send_scan(16'h1000, 16'h0001);
      end
      begin
        for (int c = 0; c < 300; c++) begin
          @(posedge clk); #1;
          bus.OUT_READY = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (stall_prev) begin
            stalls++;
            tests_run++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== data_prev) begin tests_failed++; $display("FAIL rand_hold_c%0d: got valid %b data %h expected 1 %h", c, bus.OUT_VALID, bus.OUT_DATA, data_prev); end
          end
          stall_prev = bus.OUT_VALID && !bus.OUT_READY;
          data_prev  = bus.OUT_DATA;
        end
      end
    join
    @(posedge clk); #1 bus.OUT_READY = 1'b1;
    drain(120);
    tests_run++; if (rx_q.size() != gapless_q.size()) begin tests_failed++; $display("FAIL rand_len: got %0d expected %0d", rx_q.size(), gapless_q.size()); end
    for (int i = 0; i < gapless_q.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== gapless_q[i]) begin tests_failed++; $display("FAIL rand_byte%0d: got %h expected %h", i, got, gapless_q[i]); end
    end
    tests_run++; if (bus.FRAME_DROP !== 1'b0) begin tests_failed++; $display("FAIL rand_nodrop: got %b expected 0", bus.FRAME_DROP); end
    $display("[TB] test_random_ready: %0d bytes received, %0d stalled cycles", rx_q.size(), stalls);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    bit         reached;
    do_reset();
    bus.OUT_READY = 1'b1;
    send_sample(8'd0, 16'h5555);
    send_sample(8'd2, 16'h5557);
    @(negedge clk);
    tests_run++; if (bus.SEQ_ERR !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_seq: got %b expected 1", bus.SEQ_ERR); end
    send_scan(16'h5000, 16'h0101);
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge clk);
      if (rx_q.size() >= 20) reached = 1'b1;
    end
    tests_run++; if (!reached) begin tests_failed++; $display("FAIL rst_reach20: got %0d bytes expected 20", rx_q.size()); end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ELECTRODE  = 8'd0;
    bus.RESULT     = 16'h7777;
    bus.DATA_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (bus.OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b expected 0", bus.OUT_VALID); end
    tests_run++; if (bus.SEQ_ERR !== 1'b0 || bus.FRAME_DROP !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_flags: got seq %b drop %b expected 0 0", bus.SEQ_ERR, bus.FRAME_DROP); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rx_q.delete();
    stamp_q.delete();
    repeat (5) @(posedge clk);
    #1 bus.DATA_VALID = 1'b0;
    for (int ch = 1; ch < N_CH; ch++) send_sample(8'(ch), sval(16'h5A00, 16'h0001, ch));
    drain(60);
    tests_run++; if (rx_q.size() != 0) begin tests_failed++; $display("FAIL rst_dv_held: got %0d bytes expected 0", rx_q.size()); end
    tests_run++; if (bus.SEQ_ERR !== 1'b0) begin tests_failed++; $display("FAIL rst_dv_seq: got %b expected 0", bus.SEQ_ERR); end
    send_scan(16'h6000, 16'h0001);
    drain(80);
    tests_run++; if (rx_q.size() != FRAME_BYTES) begin tests_failed++; $display("FAIL rst_after_len: got %0d expected %0d", rx_q.size(), FRAME_BYTES); end
    build_frame(0, 8'h00, 16'h6000, 16'h0001);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      tests_run++; if (got !== exp_f[i]) begin tests_failed++; $display("FAIL rst_after_byte%0d: got %h expected %h", i, got, exp_f[i]); end
    end
    $display("[TB] test_reset_mid_frame: %0d bytes received after reset", rx_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.DATA_VALID = 1'b0;
    bus.RESULT     = 16'h0000;
    bus.ELECTRODE  = 8'h00;
    bus.OUT_READY  = 1'b0;
    test_reset();
    test_gapless();
    test_misaligned();
    test_seq_err();
    test_backpressure();
    test_random_ready();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
